// File: rtl/pc_int_gen.sv
// Multi-channel PC-match interrupt stimulus generator: each channel fires on a target PC,
// holds its line until acked by a store. Optional timeout build: define PC_INT_GEN_TIMEOUT_EN.
module pc_int_gen #(
  parameter int          N_CH     = 2,
  parameter int          FIRE_W   = 4,
  parameter int          DLY_W    = 8,
  parameter logic [31:0] ACK_BASE = 32'h0000_7f20,
  parameter int          TIMEOUT  = 1024
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [31:0]                              macroscopic_pc,
  input  logic [31:0]                              m_int_addr,
  input  logic [3:0]                               m_int_byteen,
  input  logic                                     cfg_we,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cfg_ch,
  input  logic [31:0]                              cfg_pc,
  input  logic [FIRE_W-1:0]                        cfg_count,
  input  logic [DLY_W-1:0]                         cfg_delay,
  output logic [N_CH-1:0]                          interrupt,
  output logic                                     irq_any,
  output logic [N_CH-1:0]                          busy,
  output logic [N_CH-1:0]                          timeout_err,
  output logic [3*N_CH-1:0]                        dbg_state
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_PENDING = 3'd2,
    S_ASSERT  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // PC is registered so a match sampled on edge n asserts after edge n+1 (delay 0).
  logic [31:2]     pc_q;
  logic [N_CH-1:0] int_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= '0;
      interrupt <= '0;
      irq_any   <= 1'b0;
    end else begin
      pc_q      <= macroscopic_pc[31:2];
      interrupt <= int_nxt;
      irq_any   <= |int_nxt;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    localparam logic [CH_W-1:0] CH_IDX   = CH_W'(k);
    localparam logic [31:0]     ACK_ADDR = ACK_BASE + 32'(4 * k);

    state_t            state, state_nxt;
    logic [31:2]       target, target_nxt;
    logic [FIRE_W-1:0] rem, rem_nxt;
    logic [DLY_W-1:0]  dly, dly_nxt;
    logic [DLY_W-1:0]  cnt, cnt_nxt;
    logic              qual, qual_nxt;
    logic              cfg_hit, ack_hit, pc_eq, match;

    assign cfg_hit = cfg_we && (cfg_ch == CH_IDX);
    assign ack_hit = (|m_int_byteen) && (m_int_addr[31:2] == ACK_ADDR[31:2]);
    assign pc_eq   = (pc_q == target);
    assign match   = pc_eq && qual;

`ifdef PC_INT_GEN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic          terr, terr_nxt;
    logic          to_hit;
    assign to_hit = (tcnt == TW'(TIMEOUT - 1));
`endif

    always_comb begin
      state_nxt  = state;
      target_nxt = target;
      rem_nxt    = rem;
      dly_nxt    = dly;
      cnt_nxt    = cnt;
      qual_nxt   = qual | ~pc_eq;
`ifdef PC_INT_GEN_TIMEOUT_EN
      terr_nxt   = terr;
`endif
      case (state)
        S_ARMED: begin
          if (match) begin
            if (dly == '0) begin
              state_nxt = S_ASSERT;
            end else begin
              cnt_nxt   = dly;
              state_nxt = S_PENDING;
            end
          end
        end
        S_PENDING: begin
          if (cnt <= DLY_W'(1)) state_nxt = S_ASSERT;
          else                  cnt_nxt   = cnt - 1'b1;
        end
        S_ASSERT: begin
          if (ack_hit) begin
            qual_nxt  = 1'b0;
            rem_nxt   = (rem != '0) ? rem - 1'b1 : '0;
            state_nxt = (rem > FIRE_W'(1)) ? S_ARMED : S_DONE;
          end
`ifdef PC_INT_GEN_TIMEOUT_EN
          else if (to_hit) begin
            state_nxt = S_DONE;
            terr_nxt  = 1'b1;
          end
`endif
        end
        default: ;
      endcase
      // A configuration write overrides anything the FSM decided this cycle.
      if (cfg_hit) begin
`ifdef PC_INT_GEN_TIMEOUT_EN
        terr_nxt = 1'b0;
`endif
        if (cfg_count != '0) begin
          target_nxt = cfg_pc[31:2];
          rem_nxt    = cfg_count;
          dly_nxt    = cfg_delay;
          cnt_nxt    = '0;
          qual_nxt   = 1'b0;
          state_nxt  = S_ARMED;
        end else begin
          state_nxt  = S_IDLE;
        end
      end
    end

`ifdef PC_INT_GEN_TIMEOUT_EN
    assign tcnt_nxt = (state == S_ASSERT && state_nxt == S_ASSERT) ? tcnt + 1'b1 : '0;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        tcnt <= '0;
        terr <= 1'b0;
      end else begin
        tcnt <= tcnt_nxt;
        terr <= terr_nxt;
      end
    end

    assign timeout_err[k] = terr;
`else
    assign timeout_err[k] = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state  <= S_IDLE;
        target <= '0;
        rem    <= '0;
        dly    <= '0;
        cnt    <= '0;
        qual   <= 1'b0;
      end else begin
        state  <= state_nxt;
        target <= target_nxt;
        rem    <= rem_nxt;
        dly    <= dly_nxt;
        cnt    <= cnt_nxt;
        qual   <= qual_nxt;
      end
    end

    assign int_nxt[k]          = (state_nxt == S_ASSERT);
    assign busy[k]             = (state == S_ARMED) || (state == S_PENDING) || (state == S_ASSERT);
    assign dbg_state[3*k +: 3] = state;
  end

endmodule
